program_loader: RTL and testbench

- Writer side of the CPU program-memory byte-write port. It drives the write enable, the write address and the instruction byte.
- Receives a framed byte stream over a valid/ready handshake, checks each frame and writes its payload into program memory.
- Holds the CPU in reset from power-up, and during every load, until a frame passes its checksum.
- Sits between the chip input pins and the pipelined CPU top.

---
 rtl/program_loader.sv | 159 +++++++++++++++
 tb/tb_program_loader.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Program-memory loader: accepts framed bytes over valid/ready, writes each payload byte
// into program memory and releases the CPU from reset only when a frame's checksum passes.
module program_loader #(
   parameter int                    ADD_WIDTH  = 7,
   parameter int                    DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = 8'hA5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  pm_wr_en,
   output logic [ADD_WIDTH-1:0]  pm_addr,
   output logic [DATA_WIDTH-1:0] pm_data,
   output logic                  cpu_rst,
   output logic                  load_done,
   output logic                  load_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
   } state_t;

   localparam logic [31:0] DEPTH = 32'(1) << ADD_WIDTH;

   state_t                state_q, state_d;
   logic [7:0]            csum_q, csum_d;
   logic [ADD_WIDTH-1:0]  base_q, base_d;
   logic [ADD_WIDTH-1:0]  idx_q, idx_d;
   logic [DATA_WIDTH-1:0] rem_q, rem_d;
   logic                  in_ready_q, in_ready_d;
   logic                  pm_wr_en_q, pm_wr_en_d;
   logic [ADD_WIDTH-1:0]  pm_addr_q, pm_addr_d;
   logic [DATA_WIDTH-1:0] pm_data_q, pm_data_d;
   logic                  cpu_rst_q, cpu_rst_d;
   logic                  load_done_q, load_done_d;
   logic                  load_err_q, load_err_d;

   logic                  accept;
   logic [7:0]            sum_in;

   // in_ready is registered, so a transfer is judged against the registered copy
   assign accept = in_valid && in_ready_q;
   assign sum_in = csum_q + 8'(in_data);

   always_comb begin
      state_d     = state_q;
      csum_d      = csum_q;
      base_d      = base_q;
      idx_d       = idx_q;
      rem_d       = rem_q;
      pm_wr_en_d  = 1'b0;
      pm_addr_d   = pm_addr_q;
      pm_data_d   = pm_data_q;
      cpu_rst_d   = cpu_rst_q;
      load_err_d  = load_err_q;

      case (state_q)
         S_IDLE: begin
            if (accept && in_data == SYNC_BYTE) begin
               cpu_rst_d  = 1'b1;
               load_err_d = 1'b0;
               csum_d     = '0;
               state_d    = S_ADDR;
            end
         end
         S_ADDR: begin
            if (accept) begin
               base_d  = ADD_WIDTH'(in_data);
               csum_d  = sum_in;
               state_d = S_LEN;
            end
         end
         S_LEN: begin
            if (accept) begin
               csum_d = sum_in;
               rem_d  = in_data;
               idx_d  = '0;
               if (32'(in_data) > DEPTH) begin
                  state_d = S_ERR;
               end else if (in_data == '0) begin
                  state_d = S_CSUM;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               csum_d     = sum_in;
               pm_wr_en_d = 1'b1;
               pm_data_d  = in_data;
               pm_addr_d  = base_q + idx_q;
               idx_d      = idx_q + 1'b1;
               rem_d      = rem_q - DATA_WIDTH'(1);
               if (rem_q == DATA_WIDTH'(1)) begin
                  state_d = S_CSUM;
               end
            end
         end
         S_CSUM: begin
            if (accept) begin
               state_d = (sum_in == 8'h00) ? S_DONE : S_ERR;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // DONE and ERR outputs are set on entry so they appear the cycle after the deciding byte
      load_done_d = (state_d == S_DONE);
      if (state_d == S_DONE) begin
         cpu_rst_d = 1'b0;
      end
      if (state_d == S_ERR) begin
         load_err_d = 1'b1;
      end
      in_ready_d = (state_d != S_DONE) && (state_d != S_ERR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         csum_q      <= '0;
         base_q      <= '0;
         idx_q       <= '0;
         rem_q       <= '0;
         in_ready_q  <= 1'b0;
         pm_wr_en_q  <= 1'b0;
         pm_addr_q   <= '0;
         pm_data_q   <= '0;
         cpu_rst_q   <= 1'b1;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         csum_q      <= csum_d;
         base_q      <= base_d;
         idx_q       <= idx_d;
         rem_q       <= rem_d;
         in_ready_q  <= in_ready_d;
         pm_wr_en_q  <= pm_wr_en_d;
         pm_addr_q   <= pm_addr_d;
         pm_data_q   <= pm_data_d;
         cpu_rst_q   <= cpu_rst_d;
         load_done_q <= load_done_d;
         load_err_q  <= load_err_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign pm_wr_en  = pm_wr_en_q;
   assign pm_addr   = pm_addr_q;
   assign pm_data   = pm_data_q;
   assign cpu_rst   = cpu_rst_q;
   assign load_done = load_done_q;
   assign load_err  = load_err_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed frames plus random frames, with every cycle traced
// against a byte-level frame parser model.
`timescale 1ns/1ps
module tb_program_loader;
   localparam int AW   = 7;
   localparam int DW   = 8;
   localparam int MAXC = 32768;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      int            cyc;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic          clk      = 1'b0;
   logic          rst      = 1'b1;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data  = '0;
   logic          in_ready, pm_wr_en, cpu_rst, load_done, load_err;
   logic [AW-1:0] pm_addr;
   logic [DW-1:0] pm_data;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int cyc       = 0;

   wr_t        obs_wr[$];
   wr_t        exp_wr[$];
   logic [4:0] obs_tr[MAXC];   // {in_ready, cpu_rst, load_err, load_done, pm_wr_en}
   logic [4:0] exp_tr[MAXC];

   // model state: position inside the current frame (0 = hunting for sync)
   int m_pos     = 0;
   int m_len     = 0;
   int m_base    = 0;
   int m_sum     = 0;
   bit m_cpu_rst = 1'b1;
   bit m_err     = 1'b0;

   program_loader dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .pm_wr_en  (pm_wr_en),
      .pm_addr   (pm_addr),
      .pm_data   (pm_data),
      .cpu_rst   (cpu_rst),
      .load_done (load_done),
      .load_err  (load_err)
   );

   always #5 clk = ~clk;

   // Consumes one clock edge worth of input; returns the output levels expected just after it.
   function automatic logic [4:0] model_step(input int t, input bit r, input bit acc,
                                             input logic [7:0] b);
      bit done = 1'b0;
      bit bad  = 1'b0;
      bit wr   = 1'b0;
      if (r) begin
         m_pos = 0; m_cpu_rst = 1'b1; m_err = 1'b0;
         return 5'b01000;
      end
      if (acc) begin
         if (m_pos == 0) begin
            if (b == 8'hA5) begin
               m_pos = 1; m_sum = 0; m_cpu_rst = 1'b1; m_err = 1'b0;
            end
         end else if (m_pos == 1) begin
            m_base = int'(b) % (1 << AW); m_sum += int'(b); m_pos = 2;
         end else if (m_pos == 2) begin
            m_len = int'(b); m_sum += int'(b);
            if (m_len > (1 << AW)) bad = 1'b1;
            else m_pos = 3;
         end else if (m_pos < 3 + m_len) begin
            wr = 1'b1;
            exp_wr.push_back('{t + 1, AW'((m_base + m_pos - 3) % (1 << AW)), b});
            m_sum += int'(b); m_pos++;
         end else begin
            if ((m_sum + int'(b)) % 256 == 0) done = 1'b1;
            else bad = 1'b1;
         end
      end
      if (done) begin m_cpu_rst = 1'b0; m_pos = 0; end
      if (bad)  begin m_err = 1'b1; m_pos = 0; end
      return {~(done | bad), m_cpu_rst, m_err, done, wr};
   endfunction

   always @(posedge clk) begin
      logic [4:0] e;
      e = model_step(cyc, rst, in_valid && (in_ready === 1'b1), in_data);
      if (cyc + 1 < MAXC) exp_tr[cyc + 1] = e;
      cyc = cyc + 1;
   end

   always @(negedge clk) begin
      if (cyc < MAXC) obs_tr[cyc] = {in_ready, cpu_rst, load_err, load_done, pm_wr_en};
      if (pm_wr_en === 1'b1) obs_wr.push_back('{cyc, pm_addr, pm_data});
   end

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Offers one byte and returns on the negedge after it has been transferred.
   task automatic send(input logic [7:0] b, input int gap);
      for (int i = 0; i < gap; i++) begin
         in_valid = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b;
      for (int w = 0; w < 16; w++) begin
         if (in_ready === 1'b1) begin
            @(negedge clk);
            return;
         end
         @(negedge clk);
      end
      total_cnt++;
      $display("FAIL handshake_timeout: byte %02h not accepted within 16 cycles, required in_ready=1", b);
   endtask

   task automatic send_seq(input bq_t q, input int gap);
      foreach (q[i]) send(q[i], gap);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      total_cnt++; if (in_ready  !== 1'b0) $display("FAIL reset_in_ready: got %b required 0", in_ready);  else pass_cnt++;
      total_cnt++; if (pm_wr_en  !== 1'b0) $display("FAIL reset_pm_wr_en: got %b required 0", pm_wr_en);  else pass_cnt++;
      total_cnt++; if (pm_addr   !== '0)   $display("FAIL reset_pm_addr: got %h required 0", pm_addr);    else pass_cnt++;
      total_cnt++; if (pm_data   !== '0)   $display("FAIL reset_pm_data: got %h required 0", pm_data);    else pass_cnt++;
      total_cnt++; if (load_done !== 1'b0) $display("FAIL reset_load_done: got %b required 0", load_done); else pass_cnt++;
      total_cnt++; if (load_err  !== 1'b0) $display("FAIL reset_load_err: got %b required 0", load_err);  else pass_cnt++;
      total_cnt++; if (cpu_rst   !== 1'b1) $display("FAIL reset_cpu_rst: got %b required 1", cpu_rst);    else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
      total_cnt++; if (in_ready  !== 1'b1) $display("FAIL idle_in_ready: got %b required 1", in_ready);   else pass_cnt++;
      $display("reset: released, loader idle");
   endtask

   task automatic test_good_frame();
      bq_t        f  = '{8'hA5, 8'h00, 8'h03, 8'h13, 8'h05, 8'h10, 8'hD5};
      logic [7:0] ed[3] = '{8'h13, 8'h05, 8'h10};
      int         w0 = obs_wr.size();
      send_seq(f, 0);
      in_valid = 1'b0;
      total_cnt++; if (load_done !== 1'b1) $display("FAIL good_done_pulse: got %b required 1", load_done); else pass_cnt++;
      total_cnt++; if (cpu_rst   !== 1'b0) $display("FAIL good_cpu_rst: got %b required 0", cpu_rst);     else pass_cnt++;
      total_cnt++; if (load_err  !== 1'b0) $display("FAIL good_load_err: got %b required 0", load_err);   else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (load_done !== 1'b0) $display("FAIL good_done_width: got %b required 0", load_done); else pass_cnt++;
      total_cnt++; if (cpu_rst   !== 1'b0) $display("FAIL good_cpu_rst_hold: got %b required 0", cpu_rst); else pass_cnt++;
      idle(2);
      total_cnt++;
      if (obs_wr.size() - w0 != 3) $display("FAIL good_write_count: got %0d required 3", obs_wr.size() - w0);
      else begin
         pass_cnt++;
         for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (obs_wr[w0 + i].addr !== AW'(i) || obs_wr[w0 + i].data !== ed[i])
               $display("FAIL good_write_%0d: got %h=%h required %h=%h", i, obs_wr[w0 + i].addr,
                        obs_wr[w0 + i].data, AW'(i), ed[i]);
            else pass_cnt++;
         end
         total_cnt++;
         if (obs_wr[w0 + 2].cyc - obs_wr[w0].cyc != 2)
            $display("FAIL good_back_to_back: write span %0d cycles required 2", obs_wr[w0 + 2].cyc - obs_wr[w0].cyc);
         else pass_cnt++;
      end
      $display("frame A5 00 03 13 05 10 D5: good frame loaded");
   endtask

   task automatic test_bad_csum();
      bq_t f  = '{8'hA5, 8'h00, 8'h03, 8'h13, 8'h05, 8'h10, 8'hD4};
      bq_t g  = '{8'h00, 8'h03, 8'h13, 8'h05, 8'h10, 8'hD5};
      int  w0 = obs_wr.size();
      send_seq(f, 0);
      in_valid = 1'b0;
      total_cnt++; if (load_err  !== 1'b1) $display("FAIL bad_load_err: got %b required 1", load_err);   else pass_cnt++;
      total_cnt++; if (cpu_rst   !== 1'b1) $display("FAIL bad_cpu_rst: got %b required 1", cpu_rst);     else pass_cnt++;
      total_cnt++; if (load_done !== 1'b0) $display("FAIL bad_load_done: got %b required 0", load_done); else pass_cnt++;
      total_cnt++; if (in_ready  !== 1'b0) $display("FAIL bad_in_ready: got %b required 0", in_ready);   else pass_cnt++;
      idle(3);
      total_cnt++; if (load_err !== 1'b1) $display("FAIL bad_err_sticky: got %b required 1", load_err); else pass_cnt++;
      total_cnt++;
      if (obs_wr.size() - w0 != 3) $display("FAIL bad_write_count: got %0d required 3", obs_wr.size() - w0);
      else pass_cnt++;
      send(8'hA5, 0);
      total_cnt++; if (load_err !== 1'b0) $display("FAIL bad_err_clear_on_sync: got %b required 0", load_err); else pass_cnt++;
      send_seq(g, 0);
      in_valid = 1'b0;
      total_cnt++; if (load_done !== 1'b1) $display("FAIL bad_recovery_done: got %b required 1", load_done); else pass_cnt++;
      total_cnt++; if (cpu_rst   !== 1'b0) $display("FAIL bad_recovery_cpu_rst: got %b required 0", cpu_rst); else pass_cnt++;
      idle(2);
      $display("frame with CSUM D4: rejected, then good frame reloaded");
   endtask

   task automatic test_wrap_gaps();
      logic [6:0] ea[3] = '{7'h7E, 7'h7F, 7'h00};
      logic [7:0] ed[3] = '{8'hAA, 8'hBB, 8'hCC};
      int         w0    = obs_wr.size();
      send(8'hA5, 0); send(8'h7E, 0); send(8'h03, 0);
      send(8'hAA, 0); send(8'hBB, 2); send(8'hCC, 2);
      send(8'h4E, 0);
      in_valid = 1'b0;
      total_cnt++; if (load_done !== 1'b1) $display("FAIL wrap_done: got %b required 1", load_done); else pass_cnt++;
      idle(2);
      total_cnt++;
      if (obs_wr.size() - w0 != 3) $display("FAIL wrap_write_count: got %0d required 3", obs_wr.size() - w0);
      else begin
         pass_cnt++;
         for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (obs_wr[w0 + i].addr !== ea[i] || obs_wr[w0 + i].data !== ed[i])
               $display("FAIL wrap_write_%0d: got %h=%h required %h=%h", i, obs_wr[w0 + i].addr,
                        obs_wr[w0 + i].data, ea[i], ed[i]);
            else pass_cnt++;
         end
         total_cnt++;
         if (obs_wr[w0 + 1].cyc - obs_wr[w0].cyc != 3 || obs_wr[w0 + 2].cyc - obs_wr[w0 + 1].cyc != 3)
            $display("FAIL wrap_gap_spacing: spacing %0d,%0d required 3,3",
                     obs_wr[w0 + 1].cyc - obs_wr[w0].cyc, obs_wr[w0 + 2].cyc - obs_wr[w0 + 1].cyc);
         else pass_cnt++;
      end
      $display("frame A5 7E 03 AA BB CC 4E with gaps: wrapped load");
   endtask

   task automatic test_overlen();
      bq_t f  = '{8'hA5, 8'h00, 8'h81};
      int  w0 = obs_wr.size();
      send_seq(f, 0);
      in_valid = 1'b0;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL overlen_ready_low: got %b required 0", in_ready); else pass_cnt++;
      total_cnt++; if (load_err !== 1'b1) $display("FAIL overlen_err: got %b required 1", load_err);       else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL overlen_ready_back: got %b required 1", in_ready); else pass_cnt++;
      idle(2);
      total_cnt++;
      if (obs_wr.size() != w0) $display("FAIL overlen_no_writes: got %0d writes required 0", obs_wr.size() - w0);
      else pass_cnt++;
      $display("frame A5 00 81: over-length rejected");
   endtask

   task automatic test_zero_len();
      bq_t f  = '{8'h00, 8'hFF, 8'hA5, 8'h10, 8'h00, 8'hF0};
      int  w0 = obs_wr.size();
      send_seq(f, 0);
      in_valid = 1'b0;
      total_cnt++; if (load_done !== 1'b1) $display("FAIL zero_len_done: got %b required 1", load_done); else pass_cnt++;
      total_cnt++; if (load_err  !== 1'b0) $display("FAIL zero_len_err: got %b required 0", load_err);   else pass_cnt++;
      idle(2);
      total_cnt++;
      if (obs_wr.size() != w0) $display("FAIL zero_len_no_writes: got %0d writes required 0", obs_wr.size() - w0);
      else pass_cnt++;
      $display("stream 00 FF A5 10 00 F0: junk skipped, empty frame loaded");
   endtask

   task automatic test_rst_mid();
      bq_t f  = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22};
      int  w0 = obs_wr.size();
      send_seq(f, 0);
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h33;
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      total_cnt++; if (pm_wr_en !== 1'b0) $display("FAIL rst_mid_write_suppressed: got %b required 0", pm_wr_en); else pass_cnt++;
      total_cnt++; if (cpu_rst  !== 1'b1) $display("FAIL rst_mid_cpu_rst: got %b required 1", cpu_rst);          else pass_cnt++;
      total_cnt++; if (load_err !== 1'b0) $display("FAIL rst_mid_err: got %b required 0", load_err);             else pass_cnt++;
      send(8'h33, 0); send(8'h44, 0);
      idle(3);
      total_cnt++;
      if (obs_wr.size() - w0 != 2) $display("FAIL rst_mid_write_count: got %0d required 2", obs_wr.size() - w0);
      else pass_cnt++;
      $display("frame cut by reset after 2 of 3 bytes: resent bytes ignored");
   endtask

   task automatic test_random();
      bq_t        f;
      int         len, nsend, w0, e0;
      logic [7:0] sum, b, base;
      bit         good;
      for (int k = 0; k < 20; k++) begin
         f.delete();
         repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom_range(0, 255));
            f.push_back((b == 8'hA5) ? 8'h5A : b);
         end
         if ($urandom_range(0, 4) == 0) begin
            case ($urandom_range(0, 5))
               0:       len = 0;
               1:       len = 1;
               2:       len = 127;
               3:       len = 128;
               4:       len = 129;
               default: len = 255;
            endcase
         end else begin
            len = $urandom_range(1, 8);
         end
         base = 8'($urandom_range(0, 255));
         f.push_back(8'hA5); f.push_back(base); f.push_back(8'(len));
         sum   = base + 8'(len);
         nsend = (len > 128) ? 3 : len;
         for (int i = 0; i < nsend; i++) begin
            b = 8'($urandom_range(0, 255));
            f.push_back(b);
            sum = sum + b;
         end
         good = ($urandom_range(0, 3) != 0);
         f.push_back(good ? 8'(8'h00 - sum) : 8'(8'h00 - sum + 8'($urandom_range(1, 255))));
         w0 = obs_wr.size();
         e0 = exp_wr.size();
         foreach (f[i]) begin
            if ($urandom_range(0, 60) == 0) begin
               rst      = 1'b1;
               in_valid = 1'($urandom_range(0, 1));
               in_data  = 8'($urandom_range(0, 255));
               @(negedge clk);
               rst      = 1'b0;
               in_valid = 1'b0;
            end
            send(f[i], ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
         end
         idle(2);
         total_cnt++;
         if (obs_wr.size() - w0 != exp_wr.size() - e0)
            $display("FAIL random_frame_%0d_writes: got %0d required %0d", k, obs_wr.size() - w0, exp_wr.size() - e0);
         else pass_cnt++;
         $display("random frame %0d: base %02h len %0d csum %s", k, base, len, good ? "correct" : "corrupted");
      end
   endtask

   task automatic test_model_trace();
      int n;
      idle(2);
      for (int c = 1; c < cyc && c < MAXC; c++) begin
         total_cnt++;
         if (obs_tr[c] !== exp_tr[c])
            $display("FAIL trace_cycle_%0d: {ready,cpu_rst,err,done,wr} got %b required %b", c, obs_tr[c], exp_tr[c]);
         else pass_cnt++;
      end
      total_cnt++;
      if (obs_wr.size() != exp_wr.size())
         $display("FAIL trace_write_total: got %0d required %0d", obs_wr.size(), exp_wr.size());
      else pass_cnt++;
      n = (obs_wr.size() < exp_wr.size()) ? obs_wr.size() : exp_wr.size();
      for (int i = 0; i < n; i++) begin
         total_cnt++;
         if (obs_wr[i].cyc != exp_wr[i].cyc || obs_wr[i].addr !== exp_wr[i].addr || obs_wr[i].data !== exp_wr[i].data)
            $display("FAIL trace_write_%0d: got @%0d %h=%h required @%0d %h=%h", i, obs_wr[i].cyc, obs_wr[i].addr,
                     obs_wr[i].data, exp_wr[i].cyc, exp_wr[i].addr, exp_wr[i].data);
         else pass_cnt++;
      end
      $display("trace: %0d cycles and %0d writes compared", cyc - 1, n);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_good_frame();
      test_bad_csum();
      test_wrap_gaps();
      test_overlen();
      test_zero_len();
      test_rst_mid();
      test_random();
      test_model_trace();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
